// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one fifo write port between k producers.
// Define FIFO_WR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module fifo_wr_arb #(
  parameter int k = 4,
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [k-1:0]   req,
  input  logic [k*n-1:0] data,
  input  logic           full,
  output logic [k-1:0]   gnt,
  output logic [n-1:0]   data_o,
  output logic           clk_o,
  output logic           busy
);

  localparam int PW = (k > 1) ? $clog2(k) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;

  logic [1:0]    state;
  logic [n-1:0]  words [k];
  logic [PW-1:0] win;
  logic          hit;
  logic          go;

  always_comb begin
    for (int i = 0; i < k; i++) begin
      words[i] = data[i*n +: n];
    end
  end

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = k - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit = 1'b1;
        win = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] ptr;
  logic [PW:0]   idx;

  // Scan ptr+1 .. ptr+k with an explicit wrap, so non-power-of-2 k never aliases.
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 1; i <= k; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(k)) begin
        idx = idx - (PW+1)'(k);
      end
      if (!hit && req[idx[PW-1:0]]) begin
        hit = 1'b1;
        win = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PW'(k - 1);
    end else if (go) begin
      ptr <= win;
    end
  end
`endif

  assign go   = (state == IDLE) && !full && hit;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      data_o <= '0;
      clk_o  <= 1'b0;
    end else begin
      gnt   <= '0;
      clk_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            gnt    <= (k)'(1) << win;
            data_o <= words[win];
            state  <= SETUP;
          end
        end
        SETUP: begin
          clk_o <= 1'b1;
          state <= STROBE;
        end
        STROBE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a behavioural 8-deep fifo
// clocked by the arbiter's write strobe.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] data = '0;
  logic        full;
  logic [3:0]  gnt;
  logic [3:0]  data_o;
  logic        clk_o;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] mem [64];
  int wr_cnt = 0;
  int rd_cnt = 0;

  fifo_wr_arb #(.k(4), .n(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .full(full),
    .gnt(gnt), .data_o(data_o), .clk_o(clk_o), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk_o) begin
    if (wr_cnt - rd_cnt < 8) begin
      mem[wr_cnt % 64] = data_o;
      wr_cnt = wr_cnt + 1;
    end
  end

  assign full = ((wr_cnt - rd_cnt) == 8);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rd_cnt = wr_cnt;
    #0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = 16'h6024;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || clk_o !== 1'b0 || data_o !== 4'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: gnt=%b clk_o=%b data_o=%0d busy=%b want 0000 0 0 0",
               gnt, clk_o, data_o, busy);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || data_o !== 4'd4) begin
      n_bad++;
      $display("FAIL reset_first_gnt: gnt=%b data_o=%0d want 0001 4", gnt, data_o);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    data = 16'h0900;
    req  = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || data_o !== 4'd9 || busy !== 1'b1 || clk_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_grant: gnt=%b data_o=%0d busy=%b clk_o=%b want 0100 9 1 0",
               gnt, data_o, busy, clk_o);
    end
    req = '0;
    tick();
    n_cmp++;
    if (clk_o !== 1'b1 || gnt !== 4'b0000 || data_o !== 4'd9) begin
      n_bad++;
      $display("FAIL single_strobe: clk_o=%b gnt=%b data_o=%0d want 1 0000 9",
               clk_o, gnt, data_o);
    end
    tick();
    n_cmp++;
    if (clk_o !== 1'b0 || busy !== 1'b0 || data_o !== 4'd9) begin
      n_bad++;
      $display("FAIL single_idle: clk_o=%b busy=%b data_o=%0d want 0 0 9",
               clk_o, busy, data_o);
    end
    n_cmp++;
    if ((wr_cnt - rd_cnt) !== 1 || mem[rd_cnt % 64] !== 4'd9) begin
      n_bad++;
      $display("FAIL single_readback: count=%0d word=%0d want 1 9",
               wr_cnt - rd_cnt, mem[rd_cnt % 64]);
    end
    rd_cnt = wr_cnt;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    logic [3:0] exp_word [5];
    logic [3:0] rb [4];
    exp_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_word = '{4'd4, 4'd2, 4'd0, 4'd6, 4'd4};
    rb       = '{4'd4, 4'd2, 4'd0, 4'd6};
    do_reset();
    data = 16'h6024;
    req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_cmp++;
      if (gnt !== exp_gnt[g] || data_o !== exp_word[g]) begin
        n_bad++;
        $display("FAIL rr_grant%0d: gnt=%b data_o=%0d want %b %0d",
                 g, gnt, data_o, exp_gnt[g], exp_word[g]);
      end
      tick();
      n_cmp++;
      if (clk_o !== 1'b1 || gnt !== 4'b0000) begin
        n_bad++;
        $display("FAIL rr_strobe%0d: clk_o=%b gnt=%b want 1 0000", g, clk_o, gnt);
      end
      if (g == 4) req = '0;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[(rd_cnt + i) % 64] !== rb[i]) begin
        n_bad++;
        $display("FAIL rr_readback%0d: word=%0d want %0d", i, mem[(rd_cnt + i) % 64], rb[i]);
      end
    end
    rd_cnt = wr_cnt;
    tick();
  endtask

  task automatic test_full();
    int grants = 0;
    do_reset();
    data = 16'h0005;
    req  = 4'b0001;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (gnt !== 4'b0000) grants++;
    end
    n_cmp++;
    if (grants !== 8 || full !== 1'b1) begin
      n_bad++;
      $display("FAIL full_fill: grants=%0d full=%b want 8 1", grants, full);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL full_hold%0d: gnt=%b busy=%b want 0000 0", t, gnt, busy);
      end
    end
    rd_cnt = rd_cnt + 1;
    #0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL full_release: gnt=%b want 0001", gnt);
    end
    req = '0;
    tick();
    tick();
    tick();
    rd_cnt = wr_cnt;
  endtask

  task automatic test_reset_mid_strobe();
    do_reset();
    data = 16'h3000;
    req  = 4'b1000;
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (clk_o !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_strobe_pre: clk_o=%b busy=%b want 1 1", clk_o, busy);
    end
    #2;
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    n_cmp++;
    if (clk_o !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_strobe_async: clk_o=%b busy=%b gnt=%b want 0 0 0000",
               clk_o, busy, gnt);
    end
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_strobe_held: gnt=%b want 0000", gnt);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_strobe_restart: gnt=%b want 0001", gnt);
    end
    req = '0;
    tick();
    tick();
    rd_cnt = wr_cnt;
  endtask

  task automatic test_prio_mode();
    logic [3:0] exp [3];
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    exp = '{4'b0010, 4'b0010, 4'b0010};
`else
    exp = '{4'b0010, 4'b1000, 4'b0010};
`endif
    do_reset();
    data = 16'h7050;
    req  = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_cmp++;
      if (gnt !== exp[g]) begin
        n_bad++;
        $display("FAIL prio_grant%0d: gnt=%b want %b", g, gnt, exp[g]);
      end
      tick();
      tick();
      rd_cnt = wr_cnt;
    end
    req = '0;
    tick();
    rd_cnt = wr_cnt;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_reset_mid_strobe();
    test_prio_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
